// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column at a time, debounces the
// row lines and emits a one-cycle strobe carrying the code of each new key press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] MATCH_LAST = DW'(DEBOUNCE_SCANS - 1);
    localparam logic [DW-1:0] REL_DONE   = DW'(DEBOUNCE_SCANS);
    // Nibble {row, col} holds the code of that key: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_div;
    logic [3:0]    r_row_m, r_row_s;
    logic [1:0]    r_col, w_col;
    logic [1:0]    r_row_sel, w_row_sel;
    logic [DW-1:0] r_match, w_match;
    logic [DW-1:0] r_rel, w_rel;
    logic [3:0]    r_code, w_code;
    logic          r_valid, w_valid;
    logic          w_sample, w_hit;
    logic [1:0]    w_r;

    assign w_sample = r_div == DIV_LAST;
    assign w_hit    = r_row_s != 4'hF;
    assign w_r      = !r_row_s[3] ? 2'd0 : !r_row_s[2] ? 2'd1 : !r_row_s[1] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SCAN;
            r_div     <= '0;
            r_row_m   <= 4'hF;
            r_row_s   <= 4'hF;
            r_col     <= 2'd0;
            r_row_sel <= 2'd0;
            r_match   <= '0;
            r_rel     <= '0;
            r_code    <= 4'h0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_div     <= w_sample ? '0 : r_div + 1'b1;
            r_row_m   <= row;
            r_row_s   <= r_row_m;
            r_col     <= w_col;
            r_row_sel <= w_row_sel;
            r_match   <= w_match;
            r_rel     <= w_rel;
            r_code    <= w_code;
            r_valid   <= w_valid;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_col     = r_col;
        w_row_sel = r_row_sel;
        w_match   = r_match;
        w_rel     = r_rel;
        w_code    = r_code;
        w_valid   = 1'b0;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_hit) begin
                        w_state   = DEBOUNCE;
                        w_row_sel = w_r;
                        w_match   = '0;
                    end else begin
                        w_col = r_col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit && w_r == r_row_sel) begin
                        w_match = r_match + 1'b1;
                        if (w_match == MATCH_LAST) begin
                            w_state = PRESSED;
                            w_code  = KEYMAP[{r_row_sel, r_col, 2'b00} +: 4];
                            w_valid = 1'b1;
                            w_rel   = '0;
                        end
                    end else begin
                        w_state = SCAN;
                        w_col   = r_col + 2'd1;
                    end
                end
                PRESSED: begin
                    // Any low row on the held column restarts the release count
                    w_rel = w_hit ? '0 : r_rel + 1'b1;
                    if (w_rel == REL_DONE) begin
                        w_state = SCAN;
                        w_col   = r_col + 2'd1;
                    end
                end
                default: w_state = SCAN;
            endcase
        end
    end

    assign shift_col = ~(4'b1000 >> r_col);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_state == PRESSED;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus scoreboard of expected key strobes,
// directed scenarios followed by randomized presses and short glitches.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  shift_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    logic [3:0]  last_exp = 4'h0;
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;
    string       keys = "123A456B789CE0FD";

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .row(row), .shift_col(shift_col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    // Key (r,c) pulls row r low only while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !shift_col[3-c]) row[3-r] = 1'b0;
    end

    function automatic logic [3:0] code_of(input int k);
        byte ch;
        ch = keys[k];
        return (ch >= "A") ? 4'(int'(ch) - int'("A") + 10) : 4'(int'(ch) - int'("0"));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("col_one_cold", $countones(shift_col), 3);
            if (key_valid) begin
                check("valid_single", prev_valid, 0);
                check("held_on_valid", key_held, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_unexpected actual=%0h required=none", key_code);
                end else begin
                    check("strobe_code", key_code, exp_q.pop_front());
                end
            end
        end
        prev_valid <= reset ? 1'b0 : key_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        pressed[k] = 1'b1;
        exp_q.push_back(code_of(k));
        last_exp = code_of(k);
    endtask

    task automatic drained();
        check("strobe_missing", exp_q.size(), 0);
        check("code_hold", key_code, last_exp);
    endtask

    task automatic check_scan(input int n);
        logic [3:0] e;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = ~(4'b1000 >> ((k / SD) % 4));
            check("scan_seq", shift_col, e);
        end
    endtask

    task automatic wait_col_start(input logic [3:0] v);
        int i = 0;
        while (shift_col == v && i < 40) begin @(negedge clk); i++; end
        while (shift_col != v && i < 40) begin @(negedge clk); i++; end
        check_range("wait_col_bound", i, 1, 39);
        check("wait_col", shift_col, v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int g;
        cycles(3);
        check("rst_col", shift_col, 4'b0111);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        reset = 1'b0;
        check_scan(40);

        press(5);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (key_held) check("col_held", shift_col, 4'b1011);
        end
        drained();
        pressed[5] = 1'b0;
        n = 1;
        while (key_held && n < 40) begin @(negedge clk); n++; end
        check_range("release_time", n, 12, 16);
        cycles(20);
        drained();

        wait_col_start(4'b1101);
        pressed[10] = 1'b1;
        cycles(3);
        pressed[10] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 8 == 0) check("glitch_no_held", key_held, 0);
        end
        wait_col_start(4'b0111);
        drained();

        wait_col_start(4'b0111);
        pressed[15] = 1'b1;
        press(0);
        cycles(40);
        drained();
        pressed[0] = 1'b0;
        cycles(8);
        drained();
        check("two_key_still_held", key_held, 1);
        pressed[15] = 1'b0;
        cycles(60);
        drained();
        check("two_key_released", key_held, 0);

        press(14);
        cycles(50);
        pressed[14] = 1'b0;
        cycles(40);
        drained();
        press(13);
        cycles(50);
        pressed[13] = 1'b0;
        cycles(40);
        drained();

        wait_col_start(4'b0111);
        pressed[8] = 1'b1;
        cycles(6);
        reset = 1'b1;
        #1;
        check("midrst_col", shift_col, 4'b0111);
        check("midrst_valid", key_valid, 0);
        check("midrst_held", key_held, 0);
        check("midrst_code", key_code, 0);
        pressed[8] = 1'b0;
        last_exp = 4'h0;
        cycles(2);
        reset = 1'b0;
        check_scan(16);
        cycles(40);
        drained();

        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 15);
            press(k);
            cycles($urandom_range(40, 70));
            pressed[k] = 1'b0;
            cycles($urandom_range(25, 40));
            if ($urandom_range(0, 1) == 1) begin
                g = $urandom_range(0, 15);
                pressed[g] = 1'b1;
                cycles($urandom_range(1, 3));
                pressed[g] = 1'b0;
            end
            cycles(25);
            drained();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
